// File: rtl/kb_event_writer.sv
// Converts PS/2 set-2 scan-code bytes into 32-bit key-event words on a memory write port.
// Latency: kb_we_o/kb_wrdata_o are registered, one cycle after the final byte's scan_valid_i.
// No backpressure: one byte may arrive every cycle; each completed transition writes once.
// Build option: define KB_EVENT_MAKE_ONLY_EN to suppress writes for release events.
module kb_event_writer #(
  parameter logic [31:0] KB_INFO_ADDR = 32'h0050_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_valid_i,
  input  logic [7:0]  scan_code_i,
  output logic [31:0] kb_wraddr_o,
  output logic [31:0] kb_wrdata_o,
  output logic        kb_we_o
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t      state_q, state_d;
  logic [7:0]  seq_q, seq_d;
  logic        shift_q, shift_d;
  logic        ctrl_q, ctrl_d;
  logic        caps_q, caps_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic        we_q, we_d;

  logic        ev_fire, ev_ext, ev_rel, ev_emit;
  logic [7:0]  ev_ascii;

  // Set-2 make code to ASCII for the non-extended keys that have a printable mapping.
  function automatic logic [7:0] kb_ascii(input logic [7:0] code, input logic shift,
                                          input logic caps);
    logic [7:0] letter;
    logic [7:0] res;
    letter = 8'h00;
    res    = 8'h00;
    case (code)
      8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";  8'h23: letter = "d";
      8'h24: letter = "e";  8'h2B: letter = "f";  8'h34: letter = "g";  8'h33: letter = "h";
      8'h43: letter = "i";  8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
      8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";  8'h4D: letter = "p";
      8'h15: letter = "q";  8'h2D: letter = "r";  8'h1B: letter = "s";  8'h2C: letter = "t";
      8'h3C: letter = "u";  8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
      8'h35: letter = "y";  8'h1A: letter = "z";
      default: letter = 8'h00;
    endcase
    if (letter != 8'h00) begin
      // Lowercase and uppercase ASCII differ only in bit 5.
      res = (shift ^ caps) ? (letter & 8'hDF) : letter;
    end else begin
      case (code)
        8'h45: res = shift ? ")" : "0";
        8'h16: res = shift ? "!" : "1";
        8'h1E: res = shift ? "@" : "2";
        8'h26: res = shift ? "#" : "3";
        8'h25: res = shift ? "$" : "4";
        8'h2E: res = shift ? "%" : "5";
        8'h36: res = shift ? "^" : "6";
        8'h3D: res = shift ? "&" : "7";
        8'h3E: res = shift ? "*" : "8";
        8'h46: res = shift ? "(" : "9";
        8'h29: res = 8'h20;
        8'h5A: res = 8'h0A;
        8'h66: res = 8'h08;
        8'h0D: res = 8'h09;
        8'h76: res = 8'h1B;
        default: res = 8'h00;
      endcase
    end
    return res;
  endfunction

  // Prefix tracking, modifier update and event-word assembly for the current byte.
  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    shift_d  = shift_q;
    ctrl_d   = ctrl_q;
    caps_d   = caps_q;
    wrdata_d = wrdata_q;
    we_d     = 1'b0;
    ev_fire  = 1'b0;
    ev_ext   = 1'b0;
    ev_rel   = 1'b0;
    ev_emit  = 1'b0;
    ev_ascii = 8'h00;

    if (scan_valid_i) begin
      case (state_q)
        IDLE: begin
          case (scan_code_i)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            // Self-test, ack, echo, resend and error bytes carry no key transition.
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_d = IDLE;
            default: ev_fire = 1'b1;
          endcase
        end
        EXT: begin
          case (scan_code_i)
            8'hF0: state_d = EXT_BRK;
            8'hE0: state_d = EXT;
            default: begin
              ev_fire = 1'b1;
              ev_ext  = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
        BRK: begin
          case (scan_code_i)
            8'hF0: state_d = BRK;
            8'hE0: state_d = EXT_BRK;
            default: begin
              ev_fire = 1'b1;
              ev_rel  = 1'b1;
              state_d = IDLE;
            end
          endcase
        end
        default: begin
          if (scan_code_i != 8'hF0 && scan_code_i != 8'hE0) begin
            ev_fire = 1'b1;
            ev_ext  = 1'b1;
            ev_rel  = 1'b1;
            state_d = IDLE;
          end
        end
      endcase
    end

    if (ev_fire) begin
      // Modifier state changes first so the emitted flags describe the post-event state.
      if (!ev_ext && (scan_code_i == 8'h12 || scan_code_i == 8'h59)) shift_d = !ev_rel;
      if (scan_code_i == 8'h14) ctrl_d = !ev_rel;
      if (!ev_ext && !ev_rel && scan_code_i == 8'h58) caps_d = !caps_q;

`ifdef KB_EVENT_MAKE_ONLY_EN
      ev_emit = !ev_rel;
`else
      ev_emit = 1'b1;
`endif
      ev_ascii = ev_ext ? 8'h00 : kb_ascii(scan_code_i, shift_d, caps_d);

      if (ev_emit) begin
        seq_d    = seq_q + 8'd1;
        we_d     = 1'b1;
        wrdata_d = {seq_d, 3'b000, caps_d, ctrl_d, shift_d, ev_ext, ev_rel,
                    scan_code_i, ev_ascii};
      end
    end
  end

  // State, modifier, sequence and write-port registers; reset drops any pending prefix.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      seq_q    <= 8'h00;
      shift_q  <= 1'b0;
      ctrl_q   <= 1'b0;
      caps_q   <= 1'b0;
      wrdata_q <= 32'h0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      shift_q  <= shift_d;
      ctrl_q   <= ctrl_d;
      caps_q   <= caps_d;
      wrdata_q <= wrdata_d;
      we_q     <= we_d;
    end
  end

  assign kb_wraddr_o = KB_INFO_ADDR;
  assign kb_wrdata_o = wrdata_q;
  assign kb_we_o     = we_q;

endmodule

// File: tb/tb_kb_event_writer.sv
// Directed bench for kb_event_writer: table of bytes with expected write strobe and word,
// plus a back-to-back burst that wraps the sequence counter.
// Expected values follow the KB_EVENT_MAKE_ONLY_EN setting of the build.
module tb_kb_event_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_valid_i = 1'b0;
  logic [7:0]  scan_code_i = 8'h00;
  logic [31:0] kb_wraddr_o;
  logic [31:0] kb_wrdata_o;
  logic        kb_we_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  kb_event_writer dut (
    .clk          (clk),
    .rst          (rst),
    .scan_valid_i (scan_valid_i),
    .scan_code_i  (scan_code_i),
    .kb_wraddr_o  (kb_wraddr_o),
    .kb_wrdata_o  (kb_wrdata_o),
    .kb_we_o      (kb_we_o)
  );

  typedef struct {
    bit          do_rst;
    logic [7:0]  code;
    bit          exp_we;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic [7:0] c, input bit we, input logic [31:0] d);
    vec_t v;
    v.do_rst = r;
    v.code = c;
    v.exp_we = we;
    v.exp_dat = d;
    vecs.push_back(v);
  endtask

  initial begin
    int pulses;
    // Testing 1: single make of 'a'.
    add(1, 8'h00, 0, 32'h0000_0000);
    add(0, 8'h1C, 1, 32'h0100_1C61);
    // Testing 2: shift make, 'A', releases.
    add(1, 8'h00, 0, 32'h0000_0000);
    add(0, 8'h12, 1, 32'h0104_1200);
    add(0, 8'h1C, 1, 32'h0204_1C41);
    add(0, 8'hF0, 0, 32'h0204_1C41);
`ifdef KB_EVENT_MAKE_ONLY_EN
    add(0, 8'h1C, 0, 32'h0204_1C41);
    add(0, 8'hF0, 0, 32'h0204_1C41);
    add(0, 8'h12, 0, 32'h0204_1C41);
`else
    add(0, 8'h1C, 1, 32'h0305_1C41);
    add(0, 8'hF0, 0, 32'h0305_1C41);
    add(0, 8'h12, 1, 32'h0401_1200);
`endif
    // Testing 3: extended make and extended release.
    add(1, 8'h00, 0, 32'h0000_0000);
    add(0, 8'hE0, 0, 32'h0000_0000);
    add(0, 8'h75, 1, 32'h0102_7500);
    add(0, 8'hE0, 0, 32'h0102_7500);
    add(0, 8'hF0, 0, 32'h0102_7500);
`ifdef KB_EVENT_MAKE_ONLY_EN
    add(0, 8'h75, 0, 32'h0102_7500);
`else
    add(0, 8'h75, 1, 32'h0203_7500);
`endif
    // Testing 4: caps lock toggle does not affect digits.
    add(1, 8'h00, 0, 32'h0000_0000);
    add(0, 8'h58, 1, 32'h0110_5800);
    add(0, 8'hF0, 0, 32'h0110_5800);
`ifdef KB_EVENT_MAKE_ONLY_EN
    add(0, 8'h58, 0, 32'h0110_5800);
    add(0, 8'h16, 1, 32'h0210_1631);
`else
    add(0, 8'h58, 1, 32'h0211_5800);
    add(0, 8'h16, 1, 32'h0310_1631);
`endif
    // Testing 6: reset discards a pending E0 F0 prefix.
    add(1, 8'h00, 0, 32'h0000_0000);
    add(0, 8'hE0, 0, 32'h0000_0000);
    add(0, 8'hF0, 0, 32'h0000_0000);
    add(1, 8'h00, 0, 32'h0000_0000);
    add(0, 8'h1C, 1, 32'h0100_1C61);
    // Dropped byte, shifted digit, shift XOR caps, extended ctrl, enter.
    add(0, 8'hAA, 0, 32'h0100_1C61);
    add(0, 8'h12, 1, 32'h0204_1200);
    add(0, 8'h16, 1, 32'h0304_1621);
    add(0, 8'h58, 1, 32'h0414_5800);
    add(0, 8'h1C, 1, 32'h0514_1C61);
    add(0, 8'hE0, 0, 32'h0514_1C61);
    add(0, 8'h14, 1, 32'h061E_1400);
    add(0, 8'h5A, 1, 32'h071C_5A0A);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].do_rst) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        scan_valid_i = 1'b1;
        scan_code_i = vecs[i].code;
        @(negedge clk);
        scan_valid_i = 1'b0;
      end
      check($sformatf("vec%0d_we", i), {31'b0, kb_we_o}, {31'b0, vecs[i].exp_we});
      check($sformatf("vec%0d_dat", i), kb_wrdata_o, vecs[i].exp_dat);
    end

    // Testing 5: 257 back-to-back spaces, seq wraps to 01.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i <= 257; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (kb_we_o) pulses++;
        check("burst_addr", kb_wraddr_o, 32'h0050_0000);
      end
      scan_valid_i = (i < 257);
      scan_code_i = 8'h29;
    end
    check("burst_pulses", pulses, 257);
    check("burst_last", kb_wrdata_o, 32'h0100_2920);
    @(negedge clk);
    check("burst_idle_we", {31'b0, kb_we_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
